algo_dram_bank_resp: RTL and testbench
======================================

// Module: algo_dram_bank_resp
// PURPOSE
//  Memory-side responder for one t1/t2 DRAM macro port: port A read/write, port B bank refresh.
//  Stands in for the physical refreshed macro below the 1RU algorithm top.
//  Synthesizable model for emulation and standalone benches.
//  Enforces access/refresh timing rules and flags every violation.
// PARAMETERS
//  WIDTH    32    physical word width (PHYWDTH), bit-granular write enable
//  NUMSROW  2048  rows in the macro
//  BITSROW  11    row address width
//  NUMRBNK  2     refresh banks; bank of a row = addrA[BITRBNK-1:0]
//  BITRBNK  1     refresh bank index width
//  DELAY    2     read latency in cycles (>=1)
//  REFCYC   4     cycles a bank stays busy after refrB
//  BITDWSN  8     dwsn tuning bus width (captured, no functional effect)
// PORTS
//  clk      in   1        clock
//  rst      in   1        async reset, active-low (asserted at 0)
//  readA    in   1        read request, row addrA
//  writeA   in   1        write request, row addrA
//  addrA    in   BITSROW  row address
//  dinA     in   WIDTH    write data
//  bwA      in   WIDTH    per-bit write enable
//  dwsnA    in   BITDWSN  tuning; registered into dwsn_q
//  doutA    out  WIDTH    read data, valid when vldA=1
//  vldA     out  1        read data valid, DELAY cycles after readA
//  refrB    in   1        refresh request for bank bankB
//  bankB    in   BITRBNK  refresh bank
//  busy     out  NUMRBNK  per-bank refresh-in-progress
//  err      out  3        sticky: [0] rd+wr same cycle, [1] access to busy bank, [2] refr to busy bank
//  rd_cnt   out  16       read counter (see CONFIGURATION)
//  wr_cnt   out  16       write counter
//  rf_cnt   out  16       refresh counter
// BEHAVIOUR
//  Reset: doutA=0, vldA=0, busy=0, err=0, counters=0, read pipe cleared, dwsn_q=0; array NOT reset.
//  Write: mem[addrA] <= (mem & ~bwA) | (dinA & bwA) at clock edge; visible to read issued next cycle.
//  Read: mem[addrA] sampled at issue edge, shifted DELAY stages; vldA pulses 1 cycle; doutA=0 when vldA=0.
//  readA&writeA same cycle: write performed, read dropped (no vldA), err[0] set.
//  Access (rd or wr) whose bank busy: access dropped; a read still returns vldA=1 with doutA=all-ones; err[1] set.
//  Refresh: refrB with busy[bankB]=0 -> counter=REFCYC, busy[bankB]=1 next cycle, clears after REFCYC cycles.
//  refrB on busy bank: ignored, counter not restarted, err[2] set.
//  refrB and access to the same bank in one cycle: access wins (bank not yet busy), refresh starts.
//  err bits sticky until reset; rst asserted mid-read drops in-flight data, no late vldA.
// CONFIGURATION
//  Macro ALGO_DRAM_RESP_STATS_EN:
//   defined: rd_cnt/wr_cnt/rf_cnt count accepted (non-dropped) ops, saturate at 16'hFFFF.
//   undefined: counters not built, outputs tied 0.
// STRUCTURE
//  Package algo_dram_pkg: localparams ERR_RW=0, ERR_ACCBUSY=1, ERR_REFBUSY=2, CNTW=16.
//  Sub-module algo_dram_refr_timer: one per refresh bank (generate NUMRBNK).
//   Load REFCYC, count down, busy output, refr_err output.
//  Top holds array, bank decode, read delay pipe, error/counter logic.
// TESTING
//  Write 0x12345678 bw=all-ones row 5, read row 5 next cycle -> vldA at +2, doutA=0x12345678.
//  Partial write: row 5 din=0, bw=0x0000FFFF -> subsequent read 0x12340000.
//  refrB bank1 then read row 3 at +1 -> doutA=0xFFFFFFFF, err[1]=1.
//  Read row 3 at +4 after refrB -> normal data.
//  readA&writeA row 7 din=0xA5A5A5A5 -> no vldA, err[0]=1; later read returns 0xA5A5A5A5.
//  refrB bank0 twice 2 cycles apart -> busy[0] drops exactly 4 cycles after the first, err[2]=1.
//  rst low 1 cycle after readA -> no vldA, all outputs 0.
//  With STATS_EN: 3 reads, 2 writes, 1 refresh -> rd_cnt=3, wr_cnt=2, rf_cnt=1.

Source files
------------

// File: rtl/algo_dram_pkg.sv
// ---------------------------------------------------------------------------
// algo_dram_pkg
// Shared constants for the refreshed DRAM macro responder:
//   ERR_RW       err bit: read and write requested in the same cycle
//   ERR_ACCBUSY  err bit: read/write to a bank that is refreshing
//   ERR_REFBUSY  err bit: refresh request to a bank that is refreshing
//   CNTW         width of the statistics counters
// sat_inc() is a saturating increment used by the statistics counters.
// ---------------------------------------------------------------------------
package algo_dram_pkg;

    localparam int ERR_RW      = 0;
    localparam int ERR_ACCBUSY = 1;
    localparam int ERR_REFBUSY = 2;
    localparam int ERRW        = 3;
    localparam int CNTW        = 16;

    // Increment by one when en is set, holding at all-ones.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v,
                                                 input logic            en);
        if (en && (v != {CNTW{1'b1}})) begin
            return v + CNTW'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/algo_dram_refr_timer.sv
// ---------------------------------------------------------------------------
// algo_dram_refr_timer
// Busy timer for one refresh bank.
// Ports:
//   clk       clock
//   rst       asynchronous reset, active-low
//   refr      refresh request addressed to this bank
//   busy      bank is refreshing
//   refr_err  refresh requested while the bank was already busy (ignored)
// The request cycle itself counts as the first of the REFCYC refresh cycles,
// so busy is visible for REFCYC-1 cycles and drops exactly REFCYC cycles
// after the accepted request. A request on a busy bank does not restart it.
// ---------------------------------------------------------------------------
module algo_dram_refr_timer #(
    parameter int REFCYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic refr,
    output logic busy,
    output logic refr_err
);

    localparam int CW = (REFCYC > 1) ? $clog2(REFCYC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign busy     = (cnt_q != '0);
    assign refr_err = refr & busy;

    always_comb begin
        cnt_d = cnt_q;
        if (refr && !busy) begin
            cnt_d = CW'(REFCYC - 1);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/algo_dram_bank_resp.sv
// ---------------------------------------------------------------------------
// algo_dram_bank_resp
// Memory-side responder for one t1/t2 refreshed DRAM macro port.
// Port A reads/writes rows, port B refreshes banks; timing violations are
// flagged in sticky error bits.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   readA, writeA     row access requests for addrA
//   addrA             row address; its low BITRBNK bits select the bank
//   dinA, bwA         write data and per-bit write enable
//   dwsnA             tuning bus, registered only
//   doutA, vldA       read data (zero unless vldA), DELAY cycles after readA
//   refrB, bankB      refresh request and target bank
//   busy              per-bank refresh in progress
//   err               sticky {refr-to-busy, access-to-busy, rd+wr same cycle}
//   rd_cnt/wr_cnt/rf_cnt  accepted-operation counters
// Optional feature: define ALGO_DRAM_RESP_STATS_EN to build saturating
// counters; otherwise the counter outputs are tied to zero.
// The row array is not reset.
// ---------------------------------------------------------------------------
module algo_dram_bank_resp
    import algo_dram_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUMSROW = 2048,
    parameter int BITSROW = 11,
    parameter int NUMRBNK = 2,
    parameter int BITRBNK = 1,
    parameter int DELAY   = 2,
    parameter int REFCYC  = 4,
    parameter int BITDWSN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               readA,
    input  logic               writeA,
    input  logic [BITSROW-1:0] addrA,
    input  logic [WIDTH-1:0]   dinA,
    input  logic [WIDTH-1:0]   bwA,
    input  logic [BITDWSN-1:0] dwsnA,
    output logic [WIDTH-1:0]   doutA,
    output logic               vldA,
    input  logic               refrB,
    input  logic [BITRBNK-1:0] bankB,
    output logic [NUMRBNK-1:0] busy,
    output logic [ERRW-1:0]    err,
    output logic [CNTW-1:0]    rd_cnt,
    output logic [CNTW-1:0]    wr_cnt,
    output logic [CNTW-1:0]    rf_cnt
);

    logic [WIDTH-1:0] mem [NUMSROW];

    logic [NUMRBNK-1:0] bank_busy;
    logic [NUMRBNK-1:0] refr_sel;
    logic [NUMRBNK-1:0] refr_err_vec;

    logic [BITRBNK-1:0] bank_a;
    logic               acc_busy;
    logic               rw_conflict;
    logic               rd_issue;
    logic               rd_ok;
    logic               wr_ok;

    logic [DELAY-1:0]            vld_q, vld_d;
    logic [DELAY-1:0][WIDTH-1:0] dat_q, dat_d;
    logic [ERRW-1:0]             err_q, err_d;
    logic [BITDWSN-1:0]          dwsn_q;

    // ---------------- refresh timers, one per bank ----------------
    for (genvar gi = 0; gi < NUMRBNK; gi++) begin : g_bank
        assign refr_sel[gi] = refrB && (bankB == BITRBNK'(gi));

        algo_dram_refr_timer #(
            .REFCYC   (REFCYC)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .refr     (refr_sel[gi]),
            .busy     (bank_busy[gi]),
            .refr_err (refr_err_vec[gi])
        );
    end

    assign busy = bank_busy;

    // ---------------- access decode ----------------
    // Busy is sampled before this cycle's refresh takes effect, so an access
    // and a refresh to the same bank in one cycle both go ahead.
    assign bank_a      = addrA[BITRBNK-1:0];
    assign acc_busy    = bank_busy[bank_a];
    assign rw_conflict = readA & writeA;
    assign wr_ok       = writeA & ~acc_busy;
    assign rd_issue    = readA & ~writeA;
    assign rd_ok       = rd_issue & ~acc_busy;

    // ---------------- row array ----------------
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA);
        end
    end

    // ---------------- read pipe and error flags ----------------
    // Stage 0 captures the row at the issue edge; a read to a busy bank
    // still produces a valid beat carrying all-ones. Invalid stages carry
    // zero data so doutA is zero whenever vldA is low.
    always_comb begin
        vld_d    = '0;
        dat_d    = '0;
        vld_d[0] = rd_issue;
        if (rd_ok) begin
            dat_d[0] = mem[addrA];
        end else if (rd_issue) begin
            dat_d[0] = '1;
        end
        for (int k = 1; k < DELAY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end

        err_d              = err_q;
        err_d[ERR_RW]      = err_q[ERR_RW] | rw_conflict;
        err_d[ERR_ACCBUSY] = err_q[ERR_ACCBUSY] | ((readA | writeA) & acc_busy);
        err_d[ERR_REFBUSY] = err_q[ERR_REFBUSY] | (|refr_err_vec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            dat_q  <= '0;
            err_q  <= '0;
            dwsn_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            err_q  <= err_d;
            dwsn_q <= dwsnA;
        end
    end

    assign vldA  = vld_q[DELAY-1];
    assign doutA = dat_q[DELAY-1];
    assign err   = err_q;

    // The tuning value is held for observation only and drives nothing.
    logic unused_dwsn;
    assign unused_dwsn = ^dwsn_q;

    // ---------------- statistics ----------------
`ifdef ALGO_DRAM_RESP_STATS_EN
    logic            refr_ok;
    logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNTW-1:0] rf_cnt_q, rf_cnt_d;

    assign refr_ok = refrB & ~bank_busy[bankB];

    always_comb begin
        rd_cnt_d = sat_inc(rd_cnt_q, rd_ok);
        wr_cnt_d = sat_inc(wr_cnt_q, wr_ok);
        rf_cnt_d = sat_inc(rf_cnt_q, refr_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            rf_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            rf_cnt_q <= rf_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
    assign rf_cnt = rf_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
    assign rf_cnt = '0;
`endif

endmodule

// File: tb/tb_algo_dram_bank_resp.sv
// ---------------------------------------------------------------------------
// tb_algo_dram_bank_resp
// Directed bench for algo_dram_bank_resp at default parameters.
// Inputs change and outputs are sampled on the falling clock edge; a value
// seen at falling edge n reflects the rising edge just before it.
// ---------------------------------------------------------------------------
module tb_algo_dram_bank_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        readA, writeA;
    logic [10:0] addrA;
    logic [31:0] dinA, bwA;
    logic [7:0]  dwsnA;
    logic [31:0] doutA;
    logic        vldA;
    logic        refrB;
    logic [0:0]  bankB;
    logic [1:0]  busy;
    logic [2:0]  err;
    logic [15:0] rd_cnt, wr_cnt, rf_cnt;

    int total = 0;
    int bad   = 0;
    int exp_rd = 0, exp_wr = 0, exp_rf = 0;

    always #5 clk = ~clk;

    algo_dram_bank_resp dut (
        .clk    (clk),
        .rst    (rst),
        .readA  (readA),
        .writeA (writeA),
        .addrA  (addrA),
        .dinA   (dinA),
        .bwA    (bwA),
        .dwsnA  (dwsnA),
        .doutA  (doutA),
        .vldA   (vldA),
        .refrB  (refrB),
        .bankB  (bankB),
        .busy   (busy),
        .err    (err),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt),
        .rf_cnt (rf_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic idle();
        readA  = 1'b0;
        writeA = 1'b0;
        addrA  = 11'd0;
        dinA   = 32'd0;
        bwA    = 32'd0;
        refrB  = 1'b0;
        bankB  = 1'b0;
        dwsnA  = 8'h5A;
    endtask

    task automatic do_wr(input logic [10:0] addr, input logic [31:0] din, input logic [31:0] bw);
        writeA = 1'b1;
        addrA  = addr;
        dinA   = din;
        bwA    = bw;
        @(negedge clk);
        idle();
    endtask

    // Issue a read, confirm nothing one cycle later, then the beat at +2.
    task automatic do_rd(input string tag, input logic [10:0] addr, input logic [31:0] exp_d);
        readA = 1'b1;
        addrA = addr;
        @(negedge clk);
        idle();
        check({tag, "_lat1"}, 32'(vldA), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(vldA), 32'd1);
        check({tag, "_dat"}, doutA, exp_d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, doutA, 32'd0);
        check({tag, "_vld"}, 32'(vldA), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rdc"}, 32'(rd_cnt), 32'd0);
        check({tag, "_wrc"}, 32'(wr_cnt), 32'd0);
        check({tag, "_rfc"}, 32'(rf_cnt), 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Full write then read next cycle
        do_wr(11'd5, 32'h1234_5678, 32'hFFFF_FFFF); exp_wr++;
        do_rd("rd_full", 11'd5, 32'h1234_5678); exp_rd++;
        @(negedge clk);
        check("vld_pulse", 32'(vldA), 32'd0);
        check("dout_idle", doutA, 32'd0);

        // Partial write: low half cleared
        do_wr(11'd5, 32'h0000_0000, 32'h0000_FFFF); exp_wr++;
        do_rd("rd_part", 11'd5, 32'h1234_0000); exp_rd++;

        // Read and write together: write lands, read dropped
        readA  = 1'b1;
        writeA = 1'b1;
        addrA  = 11'd7;
        dinA   = 32'hA5A5_A5A5;
        bwA    = 32'hFFFF_FFFF;
        @(negedge clk);
        idle(); exp_wr++;
        check("rw_lat1", 32'(vldA), 32'd0);
        @(negedge clk);
        check("rw_novld", 32'(vldA), 32'd0);
        check("rw_err", 32'(err), 32'd1);
        do_rd("rd_rw", 11'd7, 32'hA5A5_A5A5); exp_rd++;

        // Refresh bank 1, read row 3 one cycle later (busy), then at +4
        do_wr(11'd3, 32'hCAFE_F00D, 32'hFFFF_FFFF); exp_wr++;
        refrB = 1'b1;
        bankB = 1'b1;
        @(negedge clk);
        idle(); exp_rf++;
        check("busy_b1", 32'(busy), 32'd2);
        do_rd("rd_busy", 11'd3, 32'hFFFF_FFFF);
        check("err_acc", 32'(err), 32'd3);
        @(negedge clk);
        check("busy_b1_clr", 32'(busy), 32'd0);
        do_rd("rd_after", 11'd3, 32'hCAFE_F00D); exp_rd++;

        // Refresh and read of the same bank in one cycle: read wins
        @(negedge clk);
        refrB = 1'b1;
        bankB = 1'b1;
        readA = 1'b1;
        addrA = 11'd7;
        @(negedge clk);
        idle(); exp_rf++; exp_rd++;
        check("same_busy", 32'(busy), 32'd2);
        check("same_lat1", 32'(vldA), 32'd0);
        @(negedge clk);
        check("same_vld", 32'(vldA), 32'd1);
        check("same_dat", doutA, 32'hA5A5_A5A5);
        check("same_err", 32'(err), 32'd3);
        repeat (2) @(negedge clk);
        check("same_clr", 32'(busy), 32'd0);

        // Refresh bank 0 twice, 2 cycles apart, with a dropped write between
        do_wr(11'd2, 32'h1111_1111, 32'hFFFF_FFFF); exp_wr++;
        refrB = 1'b1;
        bankB = 1'b0;
        @(negedge clk);
        idle(); exp_rf++;
        do_wr(11'd2, 32'h2222_2222, 32'hFFFF_FFFF);
        refrB = 1'b1;
        bankB = 1'b0;
        @(negedge clk);
        idle();
        check("busy0_hold", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy0_drop", 32'(busy), 32'd0);
        check("err_all", 32'(err), 32'd7);
        do_rd("rd_dropwr", 11'd2, 32'h1111_1111); exp_rd++;

`ifdef ALGO_DRAM_RESP_STATS_EN
        check("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
        check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("rf_cnt", 32'(rf_cnt), 32'(exp_rf));
`else
        check("rd_cnt_off", 32'(rd_cnt), 32'd0);
        check("wr_cnt_off", 32'(wr_cnt), 32'd0);
        check("rf_cnt_off", 32'(rf_cnt), 32'd0);
`endif

        // Reset while a read is in flight and bank 0 is refreshing
        @(negedge clk);
        refrB = 1'b1;
        bankB = 1'b0;
        readA = 1'b1;
        addrA = 11'd5;
        @(negedge clk);
        idle();
        check("prerst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b1;
        @(negedge clk);
        check("postrst_vld", 32'(vldA), 32'd0);
        check("postrst_err", 32'(err), 32'd0);
        @(negedge clk);
        check("postrst_vld2", 32'(vldA), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
